// File: rtl/raizing_layer_mixer.sv
// raizing_layer_mixer: resolves NUM_LAYERS priority-tagged layers plus an
// always-on-top text layer into one palette index per dot, through a two
// stage PIXEL_CEN pipeline. Enable mask and backdrop are CPU-written into a
// pending copy and committed to the live copy on the VBLANK rising edge.
// Optional feature macro: RAIZING_LAYER_MIXER_SOLO_EN (addr 2 solo register).
module raizing_layer_mixer #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned PIX_W      = 11,
    parameter int unsigned PRI_W      = 4,
    parameter int unsigned TEXT_EN    = 1
) (
    input  logic                                CLK,
    input  logic                                RESET_N,
    input  logic                                PIXEL_CEN,
    input  logic                                ACTIVE,
    input  logic                                VBLANK,
    input  logic [NUM_LAYERS*(PRI_W+PIX_W)-1:0] LAYER_PIXELS,
    input  logic [PIX_W-1:0]                    TEXT_PIXEL,
    input  logic [1:0]                          CPU_ADDR,
    input  logic [15:0]                         CPU_DIN,
    input  logic                                CPU_WR,
    output logic                                CPU_ACK,
    output logic [PIX_W-1:0]                    FINAL_PIXEL,
    output logic [3:0]                          FINAL_LAYER,
    output logic                                FINAL_OPAQUE
);

    localparam int unsigned LW         = PRI_W + PIX_W;
    localparam int unsigned MW         = NUM_LAYERS + 1;
    localparam logic [3:0]  LAYER_NONE = 4'hF;
    localparam logic [3:0]  LAYER_TEXT = 4'(NUM_LAYERS);

    logic [MW-1:0]    pend_mask_q, pend_mask_d, live_mask_q, live_mask_d;
    logic [PIX_W-1:0] pend_bd_q, pend_bd_d, live_bd_q, live_bd_d;
    logic [4:0]       pend_solo_q, pend_solo_d, live_solo_q, live_solo_d;
    logic             vblank_q, vblank_d, ack_q, ack_d;
    logic             vblank_rise_c;

    logic                             a_active_q, a_active_d;
    logic                             a_text_q, a_text_d;
    logic [PIX_W-1:0]                 a_text_pix_q, a_text_pix_d;
    logic [NUM_LAYERS-1:0]            a_cand_q, a_cand_d;
    logic [NUM_LAYERS-1:0][PRI_W-1:0] a_pri_q, a_pri_d;
    logic [NUM_LAYERS-1:0][PIX_W-1:0] a_idx_q, a_idx_d;

    logic [PIX_W-1:0] final_pixel_q, final_pixel_d;
    logic [3:0]       final_layer_q, final_layer_d;
    logic             final_opaque_q, final_opaque_d;

    logic [NUM_LAYERS-1:0]            cand_c;
    logic                             text_cand_c;
    logic [NUM_LAYERS-1:0][PRI_W-1:0] lay_pri_c;
    logic [NUM_LAYERS-1:0][PIX_W-1:0] lay_idx_c;
    logic [PIX_W-1:0]                 res_pixel_c;
    logic [3:0]                       res_layer_c;
    logic                             res_opaque_c;
    logic                             unused_din_c;

    assign vblank_rise_c = VBLANK & ~vblank_q;
    assign unused_din_c  = ^CPU_DIN;

    // CPU register writes into pending copies; commit pending to live on VBLANK rise
    always_comb begin
        vblank_d    = VBLANK;
        ack_d       = CPU_WR;
        pend_mask_d = pend_mask_q;
        pend_bd_d   = pend_bd_q;
        pend_solo_d = pend_solo_q;
        live_mask_d = live_mask_q;
        live_bd_d   = live_bd_q;
        live_solo_d = live_solo_q;
        if (vblank_rise_c) begin
            live_mask_d = pend_mask_q;
            live_bd_d   = pend_bd_q;
            live_solo_d = pend_solo_q;
        end
        if (CPU_WR) begin
            case (CPU_ADDR)
                2'd0:    pend_mask_d = CPU_DIN[MW-1:0];
                2'd1:    pend_bd_d   = CPU_DIN[PIX_W-1:0];
`ifdef RAIZING_LAYER_MIXER_SOLO_EN
                2'd2:    pend_solo_d = CPU_DIN[4:0];
`endif
                default: ;
            endcase
        end
    end

    // Stage A candidate qualification from live mask (and solo select)
    always_comb begin
        text_cand_c = (TEXT_EN != 0) && (TEXT_PIXEL != '0) && live_mask_q[NUM_LAYERS];
        for (int k = 0; k < NUM_LAYERS; k++) begin
            lay_idx_c[k] = LAYER_PIXELS[k*LW +: PIX_W];
            lay_pri_c[k] = LAYER_PIXELS[k*LW+PIX_W +: PRI_W];
            cand_c[k]    = (lay_idx_c[k] != '0) && live_mask_q[k];
        end
`ifdef RAIZING_LAYER_MIXER_SOLO_EN
        if (live_solo_q[4]) begin
            for (int k = 0; k < NUM_LAYERS; k++) begin
                if (live_solo_q[3:0] != 4'(k)) cand_c[k] = 1'b0;
            end
            if (live_solo_q[3:0] != LAYER_TEXT) text_cand_c = 1'b0;
        end
`endif
    end

    // Stage B resolve: text over layers; highest priority, ties to higher index
    always_comb begin
        logic             found;
        logic [PRI_W-1:0] best_pri;
        logic [PIX_W-1:0] best_idx;
        logic [3:0]       best_k;
        found    = 1'b0;
        best_pri = '0;
        best_idx = '0;
        best_k   = LAYER_NONE;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (a_cand_q[k] && (!found || a_pri_q[k] >= best_pri)) begin
                found    = 1'b1;
                best_pri = a_pri_q[k];
                best_idx = a_idx_q[k];
                best_k   = 4'(k);
            end
        end
        res_pixel_c  = live_bd_q;
        res_layer_c  = LAYER_NONE;
        res_opaque_c = 1'b0;
        if (!a_active_q) begin
            res_pixel_c = '0;
        end else if (a_text_q) begin
            res_pixel_c  = a_text_pix_q;
            res_layer_c  = LAYER_TEXT;
            res_opaque_c = 1'b1;
        end else if (found) begin
            res_pixel_c  = best_idx;
            res_layer_c  = best_k;
            res_opaque_c = 1'b1;
        end
    end

    // Pipeline advance on dot enable, hold otherwise
    always_comb begin
        a_active_d     = a_active_q;
        a_text_d       = a_text_q;
        a_text_pix_d   = a_text_pix_q;
        a_cand_d       = a_cand_q;
        a_pri_d        = a_pri_q;
        a_idx_d        = a_idx_q;
        final_pixel_d  = final_pixel_q;
        final_layer_d  = final_layer_q;
        final_opaque_d = final_opaque_q;
        if (PIXEL_CEN) begin
            a_active_d     = ACTIVE;
            a_text_d       = text_cand_c;
            a_text_pix_d   = TEXT_PIXEL;
            a_cand_d       = cand_c;
            a_pri_d        = lay_pri_c;
            a_idx_d        = lay_idx_c;
            final_pixel_d  = res_pixel_c;
            final_layer_d  = res_layer_c;
            final_opaque_d = res_opaque_c;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pend_mask_q    <= '1;
            live_mask_q    <= '1;
            pend_bd_q      <= '0;
            live_bd_q      <= '0;
            pend_solo_q    <= '0;
            live_solo_q    <= '0;
            vblank_q       <= 1'b0;
            ack_q          <= 1'b0;
            a_active_q     <= 1'b0;
            a_text_q       <= 1'b0;
            a_text_pix_q   <= '0;
            a_cand_q       <= '0;
            a_pri_q        <= '0;
            a_idx_q        <= '0;
            final_pixel_q  <= '0;
            final_layer_q  <= LAYER_NONE;
            final_opaque_q <= 1'b0;
        end else begin
            pend_mask_q    <= pend_mask_d;
            live_mask_q    <= live_mask_d;
            pend_bd_q      <= pend_bd_d;
            live_bd_q      <= live_bd_d;
            pend_solo_q    <= pend_solo_d;
            live_solo_q    <= live_solo_d;
            vblank_q       <= vblank_d;
            ack_q          <= ack_d;
            a_active_q     <= a_active_d;
            a_text_q       <= a_text_d;
            a_text_pix_q   <= a_text_pix_d;
            a_cand_q       <= a_cand_d;
            a_pri_q        <= a_pri_d;
            a_idx_q        <= a_idx_d;
            final_pixel_q  <= final_pixel_d;
            final_layer_q  <= final_layer_d;
            final_opaque_q <= final_opaque_d;
        end
    end

    assign CPU_ACK      = ack_q;
    assign FINAL_PIXEL  = final_pixel_q;
    assign FINAL_LAYER  = final_layer_q;
    assign FINAL_OPAQUE = final_opaque_q;

endmodule

// File: tb/tb_raizing_layer_mixer.sv
// Bench for raizing_layer_mixer: spec-level model plus literal spot checks.
module tb_raizing_layer_mixer;

    localparam int N  = 4;
    localparam int PW = 11;
    localparam int RW = 4;
    localparam int LW = PW + RW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cen, active, vblank, cpu_wr;
    logic [N*LW-1:0] lp;
    logic [PW-1:0] text;
    logic [1:0]    cpu_addr;
    logic [15:0]   cpu_din;
    logic          cpu_ack;
    logic [PW-1:0] final_pixel;
    logic [3:0]    final_layer;
    logic          final_opaque;

    int checks = 0;
    int errors = 0;

    raizing_layer_mixer dut (
        .CLK(clk), .RESET_N(rst_n), .PIXEL_CEN(cen), .ACTIVE(active),
        .VBLANK(vblank), .LAYER_PIXELS(lp), .TEXT_PIXEL(text),
        .CPU_ADDR(cpu_addr), .CPU_DIN(cpu_din), .CPU_WR(cpu_wr),
        .CPU_ACK(cpu_ack), .FINAL_PIXEL(final_pixel),
        .FINAL_LAYER(final_layer), .FINAL_OPAQUE(final_opaque)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] pix;
        logic [3:0]    layer;
        logic          opaque;
        logic          bd;
    } res_t;

    // What a dot resolves to, given the config in force when it was sampled
    function automatic res_t resolve(input logic [N*LW-1:0] lv, input logic [PW-1:0] tx,
                                     input logic act, input logic [N:0] mask,
                                     input logic [4:0] solo);
        res_t r;
        int best;
        logic [RW-1:0] bp, pr;
        logic [PW-1:0] ix;
        r = '{pix: '0, layer: 4'hF, opaque: 1'b0, bd: 1'b0};
        if (!act) return r;
        if (tx != 0 && mask[N] && (!solo[4] || solo[3:0] == 4'(N))) begin
            r.pix = tx; r.layer = 4'(N); r.opaque = 1'b1;
            return r;
        end
        best = -1;
        bp = '0;
        for (int k = N - 1; k >= 0; k--) begin
            ix = lv[k*LW +: PW];
            pr = lv[k*LW+PW +: RW];
            if (ix != 0 && mask[k] && (!solo[4] || solo[3:0] == 4'(k)) && (best < 0 || pr > bp)) begin
                best = k;
                bp = pr;
            end
        end
        if (best >= 0) begin
            r.pix = lv[best*LW +: PW]; r.layer = 4'(best); r.opaque = 1'b1;
        end else begin
            r.bd = 1'b1;
        end
        return r;
    endfunction

    logic [N:0]    m_mask_pend, m_mask_live;
    logic [PW-1:0] m_bd_pend, m_bd_live;
    logic [4:0]    m_solo_pend, m_solo_live;
    logic          m_vb, m_ack;
    res_t          sa;
    logic [PW-1:0] e_pix;
    logic [3:0]    e_layer;
    logic          e_opq;

    // Reference model: config double buffer and a two-dot delay line
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mask_pend <= '1; m_mask_live <= '1;
            m_bd_pend <= '0; m_bd_live <= '0;
            m_solo_pend <= '0; m_solo_live <= '0;
            m_vb <= 1'b0; m_ack <= 1'b0;
            sa <= '{pix: '0, layer: 4'hF, opaque: 1'b0, bd: 1'b0};
            e_pix <= '0; e_layer <= 4'hF; e_opq <= 1'b0;
        end else begin
            m_vb  <= vblank;
            m_ack <= cpu_wr;
            if (cen) begin
                sa      <= resolve(lp, text, active, m_mask_live, m_solo_live);
                e_pix   <= sa.bd ? m_bd_live : sa.pix;
                e_layer <= sa.layer;
                e_opq   <= sa.opaque;
            end
            if (vblank && !m_vb) begin
                m_mask_live <= m_mask_pend;
                m_bd_live   <= m_bd_pend;
                m_solo_live <= m_solo_pend;
            end
            if (cpu_wr) begin
                case (cpu_addr)
                    2'd0: m_mask_pend <= cpu_din[N:0];
                    2'd1: m_bd_pend   <= cpu_din[PW-1:0];
`ifdef RAIZING_LAYER_MIXER_SOLO_EN
                    2'd2: m_solo_pend <= cpu_din[4:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            cmp("model_pixel", int'(final_pixel), int'(e_pix));
            cmp("model_layer", int'(final_layer), int'(e_layer));
            cmp("model_opaque", int'(final_opaque), int'(e_opq));
            cmp("model_ack", int'(cpu_ack), int'(m_ack));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_now(input string name, input int pix, input int layer, input int opq);
        cmp({name, "_pixel"}, int'(final_pixel), pix);
        cmp({name, "_layer"}, int'(final_layer), layer);
        cmp({name, "_opaque"}, int'(final_opaque), opq);
    endtask

    task automatic chk(input string name, input int pix, input int layer, input int opq);
        @(negedge clk);
        chk_now(name, pix, layer, opq);
    endtask

    task automatic lay(input int k, input int pri, input int idx);
        lp[k*LW +: LW] = {4'(pri), 11'(idx)};
    endtask

    task automatic cpu_write(input int addr, input int din);
        cpu_wr = 1'b1; cpu_addr = 2'(addr); cpu_din = 16'(din);
        step();
        cpu_wr = 1'b0;
    endtask

    task automatic vblank_pulse();
        vblank = 1'b1;
        step();
        vblank = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; cen = 1'b0; active = 1'b0; vblank = 1'b0; cpu_wr = 1'b0;
        lp = '0; text = '0; cpu_addr = '0; cpu_din = '0;
        step(); step();
        chk("reset", 0, 15, 0);
        cmp("reset_ack", int'(cpu_ack), 0);
        rst_n = 1'b1;

        // Tie on priority goes to higher layer index
        cen = 1'b1; active = 1'b1;
        lay(0, 2, 'h010); lay(3, 2, 'h300);
        step(); step();
        chk("tie", 'h300, 3, 1);

        // Priority, then text on top
        lp = '0; lay(1, 9, 'h111); lay(3, 5, 'h333);
        step(); step();
        chk("prio", 'h111, 1, 1);
        text = 'h7FF;
        step(); step();
        chk("text", 'h7FF, 4, 1);

        // Backdrop is double-buffered
        text = '0; lp = '0;
        step(); step();
        chk("bd_old", 0, 15, 0);
        cpu_write(1, 'h055);
        @(negedge clk); cmp("ack_pulse", int'(cpu_ack), 1);
        step();
        @(negedge clk); cmp("ack_drop", int'(cpu_ack), 0);
        step(); step();
        chk("bd_hold", 0, 15, 0);
        vblank_pulse();
        chk("bd_new", 'h055, 15, 0);

        // Back-to-back strobes to the reserved register
        cpu_wr = 1'b1; cpu_addr = 2'd3; cpu_din = 16'hFFFF;
        step();
        @(negedge clk); cmp("ack_b2b_1", int'(cpu_ack), 1);
        step();
        cpu_wr = 1'b0;
        @(negedge clk); cmp("ack_b2b_2", int'(cpu_ack), 1);
        step();
        @(negedge clk); cmp("ack_b2b_end", int'(cpu_ack), 0);
        vblank_pulse();
        chk("rsvd_discard", 'h055, 15, 0);

        // Mask: layer 3 off only after VBLANK; priority 0 still wins
        lay(3, 15, 'h333); lay(0, 0, 'h001);
        cpu_write(0, 'h17);
        step();
        chk("mask_before", 'h333, 3, 1);
        vblank_pulse();
        step();
        chk("mask_after", 'h001, 0, 1);

        // PIXEL_CEN low holds everything
        cen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            lay(2, 1 + i, 'h222 + i);
            step();
            chk("cen_hold", 'h001, 0, 1);
        end
        cen = 1'b1; active = 1'b0;
        step(); step();
        chk("inactive", 0, 15, 0);
        active = 1'b1;

        // Text masked off
        lp = '0; lay(0, 0, 'h001); lay(3, 15, 'h333); text = 'h7FF;
        cpu_write(0, 'h0F);
        vblank_pulse();
        step();
        chk("text_masked", 'h333, 3, 1);

        // Reset mid-frame restores the all-ones live mask at once
        rst_n = 1'b0;
        #1;
        chk_now("midreset", 0, 15, 0);
        step();
        rst_n = 1'b1;
        text = '0;
        step(); step();
        chk("postreset", 'h333, 3, 1);

`ifdef RAIZING_LAYER_MIXER_SOLO_EN
        lp = '0; lay(1, 15, 'h111); lay(2, 0, 'h222); text = 'h7FF;
        cpu_write(1, 'h0AA);
        cpu_write(2, 'h12);
        vblank_pulse();
        step();
        chk("solo_l2", 'h222, 2, 1);
        lay(2, 0, 0);
        step(); step();
        chk("solo_transp", 'h0AA, 15, 0);
        lay(2, 3, 'h222);
        cpu_write(2, 'h1E);
        vblank_pulse();
        step();
        chk("solo_oor", 'h0AA, 15, 0);
`endif

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
